// File: rtl/cpu_regs_pkg.sv
// Shared constants, types and helpers for the gateboy CPU register bank.
// Registers pair as (even, odd): the even register is always the high byte.
package cpu_regs_pkg;
   localparam int DATA_WIDTH = 8;
   localparam int NUM_REGS   = 8;
   localparam int REG_W      = $clog2(NUM_REGS);

   typedef logic [DATA_WIDTH-1:0]   regData_t;
   typedef logic [2*DATA_WIDTH-1:0] pairData_t;
   typedef logic [REG_W-1:0]        regIdx_t;
   typedef logic [REG_W-2:0]        pairIdx_t;

   typedef enum regIdx_t {
      REG_B = 3'd0,
      REG_C = 3'd1,
      REG_D = 3'd2,
      REG_E = 3'd3,
      REG_H = 3'd4,
      REG_L = 3'd5,
      REG_F = 3'd6,
      REG_A = 3'd7
   } regName_e;

   function automatic regIdx_t pair_base(input regIdx_t r);
      return {r[REG_W-1:1], 1'b0};
   endfunction
endpackage

// File: rtl/register_bank_if.sv
// Read/write port of the register bank. REGISTER_BANK_PAIR_WRITE_EN adds the
// 16-bit pair write signals.
interface register_bank_if
   import cpu_regs_pkg::*;
();
   regData_t  dataIn;
   regData_t  dataOut;
   pairData_t dataOut16;
   regIdx_t   regNum;
   logic      writeEnable;
`ifdef REGISTER_BANK_PAIR_WRITE_EN
   logic      writeEnable16;
   pairData_t dataIn16;

   modport master (
      output dataIn, regNum, writeEnable, writeEnable16, dataIn16,
      input  dataOut, dataOut16
   );
   modport slave (
      input  dataIn, regNum, writeEnable, writeEnable16, dataIn16,
      output dataOut, dataOut16
   );
`else
   modport master (
      output dataIn, regNum, writeEnable,
      input  dataOut, dataOut16
   );
   modport slave (
      input  dataIn, regNum, writeEnable,
      output dataOut, dataOut16
   );
`endif
endinterface

// File: rtl/register_bank.sv
// Eight 8-bit CPU registers with a single write-first port and 8/16-bit reads.
// Optional pair write port enabled by REGISTER_BANK_PAIR_WRITE_EN.
module register_bank
   import cpu_regs_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   register_bank_if.slave  bus
);
   regData_t registers [NUM_REGS];
   regData_t nextRegs  [NUM_REGS];
   regIdx_t  evenIdx;
   regIdx_t  oddIdx;

   assign evenIdx = pair_base(bus.regNum);
   assign oddIdx  = evenIdx | regIdx_t'(1);

   // Outputs are taken from the post-write image, which gives write-first reads.
   always_comb begin
      nextRegs = registers;
`ifdef REGISTER_BANK_PAIR_WRITE_EN
      if (bus.writeEnable16) begin
         nextRegs[evenIdx] = bus.dataIn16[2*DATA_WIDTH-1:DATA_WIDTH];
         nextRegs[oddIdx]  = bus.dataIn16[DATA_WIDTH-1:0];
      end else if (bus.writeEnable) begin
         nextRegs[bus.regNum] = bus.dataIn;
      end
`else
      if (bus.writeEnable) begin
         nextRegs[bus.regNum] = bus.dataIn;
      end
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            registers[i] <= '0;
         end
         bus.dataOut   <= '0;
         bus.dataOut16 <= '0;
      end else begin
         registers     <= nextRegs;
         bus.dataOut   <= nextRegs[bus.regNum];
         bus.dataOut16 <= {nextRegs[evenIdx], nextRegs[oddIdx]};
      end
   end
endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank: directed steps plus random traffic
// against an array model; pair-write checks under REGISTER_BANK_PAIR_WRITE_EN.
module tb_register_bank;
   import cpu_regs_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   model [8];
   int   expOut = 0;
   int   expOut16 = 0;

   register_bank_if bus();

   register_bank dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic checkAllRegs(input string tag);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("%s_r%0d", tag, i), {8'h00, dut.registers[i]}, 16'(model[i]));
      end
   endtask

   // One clock with the given inputs; the model applies the same edge afterwards.
   task automatic step(input int rn, input int we, input int din, input int we16, input int d16);
      @(negedge clk);
      bus.regNum      = 3'(rn);
      bus.writeEnable = 1'(we);
      bus.dataIn      = 8'(din);
`ifdef REGISTER_BANK_PAIR_WRITE_EN
      bus.writeEnable16 = 1'(we16);
      bus.dataIn16      = 16'(d16);
`endif
      @(posedge clk);
`ifdef REGISTER_BANK_PAIR_WRITE_EN
      if (we16 != 0) begin
         model[(rn / 2) * 2]     = (d16 / 256) % 256;
         model[(rn / 2) * 2 + 1] = d16 % 256;
      end else if (we != 0) begin
         model[rn] = din % 256;
      end
`else
      if (we != 0 || we16 != 0 && 1'b0) model[rn] = din % 256;
`endif
      expOut   = model[rn];
      expOut16 = model[(rn / 2) * 2] * 256 + model[(rn / 2) * 2 + 1];
      #1;
   endtask

   task automatic clearBank();
      for (int i = 0; i < 8; i++) step(i, 1, 0, 0, 0);
   endtask

   initial begin
      int rn, we, din, we16, d16;
      bit [7:0] preload [8];
      bit [15:0] pairExp [8];
      preload = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hBA, 8'hBA, 8'hBA, 8'hBE};
      pairExp = '{16'hDEAD, 16'hDEAD, 16'hBEEF, 16'hBEEF, 16'hBABA, 16'hBABA, 16'hBABE, 16'hBABE};
      for (int i = 0; i < 8; i++) model[i] = 0;

      bus.regNum = '0;
      bus.writeEnable = 1'b0;
      bus.dataIn = '0;
`ifdef REGISTER_BANK_PAIR_WRITE_EN
      bus.writeEnable16 = 1'b0;
      bus.dataIn16 = '0;
`endif
      // Reset held low across edges, with a write request that must be ignored.
      bus.writeEnable = 1'b1;
      bus.dataIn = 8'h77;
      repeat (3) @(posedge clk);
      #1;
      check("rst_dataOut", {8'h00, bus.dataOut}, 16'h0000);
      check("rst_dataOut16", bus.dataOut16, 16'h0000);
      checkAllRegs("rst");
      @(negedge clk);
      bus.writeEnable = 1'b0;
      reset = 1'b1;

      // Single writes, then a read-only cycle with different dataIn.
      for (int i = 0; i < 8; i++) begin
         clearBank();
         step(i, 1, 8'hFF, 0, 0);
         check($sformatf("wr%0d_dataOut", i), {8'h00, bus.dataOut}, 16'h00FF);
         checkAllRegs($sformatf("wr%0d", i));
         step(i, 0, 8'hF0, 0, 0);
         check($sformatf("rd%0d_dataOut", i), {8'h00, bus.dataOut}, 16'h00FF);
         check($sformatf("rd%0d_reg", i), {8'h00, dut.registers[i]}, 16'h00FF);
      end

      // Pair read table.
      for (int i = 0; i < 8; i++) step(i, 1, preload[i], 0, 0);
      for (int i = 0; i < 8; i++) begin
         step(i, 0, 8'h33, 0, 0);
         check($sformatf("pair%0d_dataOut16", i), bus.dataOut16, pairExp[i]);
         check($sformatf("pair%0d_dataOut", i), {8'h00, bus.dataOut}, {8'h00, preload[i]});
      end

      // Write-first on the odd byte of a pair.
      step(2, 1, 8'h12, 0, 0);
      step(3, 1, 8'h5A, 0, 0);
      check("wf_dataOut", {8'h00, bus.dataOut}, 16'h005A);
      check("wf_dataOut16", bus.dataOut16, 16'h125A);
      step(2, 1, 8'hC3, 0, 0);
      check("wf_even_dataOut16", bus.dataOut16, 16'hC35A);

      // Async reset between edges during a write sequence.
      step(6, 1, 8'h9C, 0, 0);
      @(negedge clk);
      bus.regNum = 3'd1;
      bus.writeEnable = 1'b1;
      bus.dataIn = 8'h44;
      #2 reset = 1'b0;
      #1;
      for (int i = 0; i < 8; i++) model[i] = 0;
      check("arst_dataOut", {8'h00, bus.dataOut}, 16'h0000);
      check("arst_dataOut16", bus.dataOut16, 16'h0000);
      checkAllRegs("arst");
      @(posedge clk);
      #1;
      checkAllRegs("arst_edge");
      check("arst_edge_dataOut", {8'h00, bus.dataOut}, 16'h0000);
      @(negedge clk);
      reset = 1'b1;
      bus.writeEnable = 1'b0;

`ifdef REGISTER_BANK_PAIR_WRITE_EN
      step(5, 0, 0, 1, 16'hC0DE);
      check("pw_dataOut16", bus.dataOut16, 16'hC0DE);
      check("pw_dataOut", {8'h00, bus.dataOut}, 16'h00DE);
      check("pw_r4", {8'h00, dut.registers[4]}, 16'h00C0);
      check("pw_r5", {8'h00, dut.registers[5]}, 16'h00DE);
      step(2, 1, 8'h11, 1, 16'hABCD);
      check("pw_prio_dataOut16", bus.dataOut16, 16'hABCD);
      check("pw_prio_dataOut", {8'h00, bus.dataOut}, 16'h00AB);
`endif

      // Random traffic against the model.
      for (int n = 0; n < 300; n++) begin
         rn   = int'($urandom_range(7));
         we   = int'($urandom_range(1));
         din  = int'($urandom_range(255));
         we16 = 0;
         d16  = int'($urandom_range(65535));
`ifdef REGISTER_BANK_PAIR_WRITE_EN
         we16 = ($urandom_range(3) == 0) ? 1 : 0;
`endif
         step(rn, we, din, we16, d16);
         check("rnd_dataOut", {8'h00, bus.dataOut}, 16'(expOut));
         check("rnd_dataOut16", bus.dataOut16, 16'(expOut16));
      end
      checkAllRegs("final");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
